counter_updown_param: RTL and testbench

COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

---
 rtl/counter_updown_param.sv | 108 ++++++++++
 tb/tb_counter_updown_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_param.sv
// Parameterised up/down counter with a bounded range, an enable prescaler,
// wrap or saturate behaviour at the bounds, and a registered terminal-count pulse.
module counter_updown_param #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 200,
    parameter int MIN_VALUE = 0,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    // Prescaler needs at least one bit even when every enabled cycle is a step.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VALUE);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    // Reject parameter sets whose range cannot be represented or is empty.
    if (WIDTH < 1 || WIDTH > 62) begin : g_bad_width
        $error("counter_updown_param: WIDTH must be in 1..62");
    end
    if (MIN_VALUE < 0 || MIN_VALUE >= MAX_VALUE) begin : g_bad_range
        $error("counter_updown_param: need 0 <= MIN_VALUE < MAX_VALUE");
    end
    if (longint'(MAX_VALUE) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
        $error("counter_updown_param: MAX_VALUE does not fit in WIDTH bits");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_updown_param: PRESCALE must be at least 1");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             tc_q, tc_d;

    // Loaded values are forced into the legal range so the count never escapes it.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        if (v >= MAX_W) begin
            return MAX_W;
        end
        if (v <= MIN_W) begin
            return MIN_W;
        end
        return v;
    endfunction

    // Next-state: load beats stepping; a step happens on the last prescaler slot.
    always_comb begin
        cnt_d = cnt_q;
        ps_d  = ps_q;
        tc_d  = 1'b0;
        if (load) begin
            cnt_d = clamp_load(load_value);
            ps_d  = '0;
        end else if (en) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                if (up_down) begin
                    if (cnt_q == MAX_W) begin
                        tc_d  = 1'b1;
                        cnt_d = (SATURATE != 0) ? MAX_W : MIN_W;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == MIN_W) begin
                        tc_d  = 1'b1;
                        cnt_d = (SATURATE != 0) ? MIN_W : MAX_W;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    // State registers; reset discards count and prescaler progress.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q <= MIN_W;
            ps_q  <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ps_q  <= ps_d;
            tc_q  <= tc_d;
        end
    end

    assign counter = cnt_q;
    assign tc      = tc_q;
    assign at_max  = (cnt_q == MAX_W);
    assign at_min  = (cnt_q == MIN_W);

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: four differently parameterised instances share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_counter_updown_param;

    localparam int N = 4;
    localparam int P_MAX [N] = '{200, 200, 200, 200};
    localparam int P_MIN [N] = '{0, 0, 0, 10};
    localparam int P_PS  [N] = '{1, 1, 4, 3};
    localparam int P_SAT [N] = '{0, 1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RST = 1'b1;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;

    logic [7:0] cnt_o  [N];
    logic       tc_o   [N];
    logic       amax_o [N];
    logic       amin_o [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        counter_updown_param #(
            .WIDTH(8), .MAX_VALUE(P_MAX[g]), .MIN_VALUE(P_MIN[g]),
            .PRESCALE(P_PS[g]), .SATURATE(P_SAT[g])
        ) dut (
            .clk(clk), .RST(RST), .en(en), .up_down(up_down), .load(load),
            .load_value(load_value), .counter(cnt_o[g]), .tc(tc_o[g]),
            .at_max(amax_o[g]), .at_min(amin_o[g])
        );
    end

    // Model state: count value, enabled cycles since last step, tc pulse.
    int m_cnt [N];
    int m_acc [N];
    int m_tc  [N];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            m_tc[i] = 0;
            if (RST) begin
                m_cnt[i] = P_MIN[i];
                m_acc[i] = 0;
            end else if (load) begin
                m_cnt[i] = int'(load_value);
                if (m_cnt[i] > P_MAX[i]) m_cnt[i] = P_MAX[i];
                if (m_cnt[i] < P_MIN[i]) m_cnt[i] = P_MIN[i];
                m_acc[i] = 0;
            end else if (en) begin
                m_acc[i] = m_acc[i] + 1;
                if (m_acc[i] == P_PS[i]) begin
                    m_acc[i] = 0;
                    if (up_down) begin
                        if (m_cnt[i] == P_MAX[i]) begin
                            m_tc[i] = 1;
                            if (P_SAT[i] == 0) m_cnt[i] = P_MIN[i];
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end else begin
                        if (m_cnt[i] == P_MIN[i]) begin
                            m_tc[i] = 1;
                            if (P_SAT[i] == 0) m_cnt[i] = P_MAX[i];
                        end else begin
                            m_cnt[i] = m_cnt[i] - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d.counter", i), int'(cnt_o[i]), m_cnt[i]);
            check($sformatf("u%0d.tc", i), int'(tc_o[i]), m_tc[i]);
            check($sformatf("u%0d.at_max", i), int'(amax_o[i]), int'(m_cnt[i] == P_MAX[i]));
            check($sformatf("u%0d.at_min", i), int'(amin_o[i]), int'(m_cnt[i] == P_MIN[i]));
        end
    endtask

    // One clock: inputs are stable across the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int bias;

        // Reset
        RST = 1'b1;
        tick();
        tick();
        check("reset.counter", int'(cnt_o[0]), 0);
        check("reset.tc", int'(tc_o[0]), 0);
        check("reset.u3.counter", int'(cnt_o[3]), 10);

        // Full up run with wrap on the defaults instance
        RST = 1'b0; en = 1'b1; up_down = 1'b1;
        for (int k = 1; k <= 201; k++) begin
            tick();
            if (k <= 200) check("run.counter", int'(cnt_o[0]), k);
            if (k == 200) begin
                check("run.at_max", int'(amax_o[0]), 1);
                check("run.tc_before_wrap", int'(tc_o[0]), 0);
            end
        end
        check("wrap.counter", int'(cnt_o[0]), 0);
        check("wrap.tc", int'(tc_o[0]), 1);
        check("sat_up.counter", int'(cnt_o[1]), 200);
        check("sat_up.tc", int'(tc_o[1]), 1);
        check("ps4_run.counter", int'(cnt_o[2]), 50);
        tick();
        check("wrap.tc_one_cycle", int'(tc_o[0]), 0);

        // Saturating down at the minimum pulses tc every step
        RST = 1'b1; tick(); RST = 1'b0;
        up_down = 1'b0; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sat_dn.counter", int'(cnt_o[1]), 0);
            check("sat_dn.tc", int'(tc_o[1]), 1);
            check("sat_dn.at_min", int'(amin_o[1]), 1);
        end

        // Wrapping down from 0, then a direction change
        RST = 1'b1; tick(); RST = 1'b0;
        up_down = 1'b0; en = 1'b1;
        tick();
        check("dn_wrap.counter", int'(cnt_o[0]), 200);
        check("dn_wrap.tc", int'(tc_o[0]), 1);
        up_down = 1'b1;
        tick();
        check("dir_chg.counter", int'(cnt_o[0]), 0);
        check("dir_chg.tc", int'(tc_o[0]), 1);
        tick();
        check("dir_chg2.counter", int'(cnt_o[0]), 1);

        // Prescale by 4 with an enable gap
        RST = 1'b1; tick(); RST = 1'b0;
        up_down = 1'b1; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) check("ps4.c3", int'(cnt_o[2]), 0);
            if (k == 4) check("ps4.c4", int'(cnt_o[2]), 1);
            if (k == 7) check("ps4.c7", int'(cnt_o[2]), 1);
            if (k == 8) check("ps4.c8", int'(cnt_o[2]), 2);
        end
        en = 1'b0; tick(); tick();
        check("ps4.gap", int'(cnt_o[2]), 2);
        en = 1'b1; tick(); tick(); tick();
        check("ps4.after_gap3", int'(cnt_o[2]), 2);
        tick();
        check("ps4.after_gap4", int'(cnt_o[2]), 3);

        // Reset mid-prescale discards progress
        en = 1'b0; load = 1'b1; load_value = 8'd150;
        tick();
        load = 1'b0;
        check("mid.load", int'(cnt_o[2]), 150);
        en = 1'b1; tick(); tick();
        check("mid.pre2", int'(cnt_o[2]), 150);
        RST = 1'b1; tick();
        check("mid.rst.counter", int'(cnt_o[2]), 0);
        check("mid.rst.tc", int'(tc_o[2]), 0);
        RST = 1'b0; tick(); tick(); tick();
        check("mid.three", int'(cnt_o[2]), 0);
        tick();
        check("mid.four", int'(cnt_o[2]), 1);

        // Loads: clamping and priority over a step
        en = 1'b0; load = 1'b1; load_value = 8'd250;
        tick();
        check("load_hi.counter", int'(cnt_o[0]), 200);
        check("load_hi.tc", int'(tc_o[0]), 0);
        load_value = 8'd7;
        tick();
        check("load_lo.u3", int'(cnt_o[3]), 10);
        check("load_lo.u0", int'(cnt_o[0]), 7);
        load_value = 8'd200;
        tick();
        load_value = 8'd5; en = 1'b1; up_down = 1'b1;
        tick();
        check("load_step.counter", int'(cnt_o[0]), 5);
        check("load_step.tc", int'(tc_o[0]), 0);
        load = 1'b0;

        // Randomised segments with a drifting direction bias
        for (int seg = 0; seg < 10; seg++) begin
            bias = int'($urandom_range(0, 10));
            for (int k = 0; k < 300; k++) begin
                en         = ($urandom_range(0, 3) != 0);
                up_down    = (int'($urandom_range(0, 9)) < bias);
                load       = ($urandom_range(0, 49) == 0);
                load_value = 8'($urandom);
                RST        = ($urandom_range(0, 199) == 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
